// File: rtl/box_draw_arbiter.sv
// Locks the single box drawer to one of three box requesters for a whole sequence.
// Optional BOX_ARB_FIXED_PRIORITY_EN selects fixed priority 0 > 1 > 2 instead of round-robin.
module box_draw_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  s_valid,
    output logic [2:0]  s_ready,
    input  logic [2:0]  s_last,
    input  logic [26:0] s_box_x,
    input  logic [26:0] s_box_y,
    input  logic [26:0] s_box_w,
    input  logic [26:0] s_box_h,
    input  logic [8:0]  s_box_color,
    input  logic        m_ready,
    output logic        m_valid,
    output logic [8:0]  out_box_x,
    output logic [8:0]  out_box_y,
    output logic [8:0]  out_box_w,
    output logic [8:0]  out_box_h,
    output logic [2:0]  out_box_color,
    output logic [1:0]  m_src,
    output logic        busy
);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          state, state_nxt;
    logic [1:0]      grant, grant_nxt;
    logic [1:0]      last_grant, last_grant_nxt;
    logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
    logic [1:0]      winner;
    logic            winner_found;
    logic            sel_valid, sel_last, xfer;
    logic [8:0]      sel_x, sel_y, sel_w, sel_h;
    logic [2:0]      sel_color;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd2;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

`ifdef BOX_ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner       = 2'd0;
        winner_found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!winner_found && s_valid[i]) begin
                winner       = 2'(i);
                winner_found = 1'b1;
            end
        end
    end
`else
    // Search starts just after the last released requester so it ranks lowest.
    always_comb begin
        int start;
        int c;
        winner       = 2'd0;
        winner_found = 1'b0;
        start        = (last_grant == 2'd2) ? 0 : int'(last_grant) + 1;
        for (int k = 0; k < 3; k++) begin
            c = start + k;
            if (c >= 3) c = c - 3;
            if (!winner_found && s_valid[c]) begin
                winner       = 2'(c);
                winner_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_w     = '0;
        sel_h     = '0;
        sel_color = '0;
        case (grant)
            2'd0: begin
                sel_valid = s_valid[0];  sel_last = s_last[0];
                sel_x = s_box_x[8:0];    sel_y = s_box_y[8:0];
                sel_w = s_box_w[8:0];    sel_h = s_box_h[8:0];
                sel_color = s_box_color[2:0];
            end
            2'd1: begin
                sel_valid = s_valid[1];  sel_last = s_last[1];
                sel_x = s_box_x[17:9];   sel_y = s_box_y[17:9];
                sel_w = s_box_w[17:9];   sel_h = s_box_h[17:9];
                sel_color = s_box_color[5:3];
            end
            2'd2: begin
                sel_valid = s_valid[2];  sel_last = s_last[2];
                sel_x = s_box_x[26:18];  sel_y = s_box_y[26:18];
                sel_w = s_box_w[26:18];  sel_h = s_box_h[26:18];
                sel_color = s_box_color[8:6];
            end
            default: ;
        endcase
    end

    assign xfer = (state == S_GRANT) && sel_valid && m_ready;

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        s_ready        = 3'b000;
        m_valid        = 1'b0;
        m_src          = 2'd3;
        busy           = 1'b0;
        out_box_x      = 9'd0;
        out_box_y      = 9'd0;
        out_box_w      = 9'd1;
        out_box_h      = 9'd1;
        out_box_color  = 3'd0;
        case (state)
            S_IDLE: begin
                if (winner_found) begin
                    grant_nxt     = winner;
                    burst_cnt_nxt = '0;
                    state_nxt     = S_GRANT;
                end
            end
            S_GRANT: begin
                m_valid       = sel_valid;
                out_box_x     = sel_x;
                out_box_y     = sel_y;
                out_box_w     = sel_w;
                out_box_h     = sel_h;
                out_box_color = sel_color;
                s_ready       = m_ready ? (3'b001 << grant) : 3'b000;
                m_src         = grant;
                busy          = 1'b1;
                if (xfer) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    // A burst cap reached on the same box as s_last is still one release.
                    if (sel_last || burst_cnt == CW'(MAX_BURST - 1)) begin
                        state_nxt      = S_IDLE;
                        last_grant_nxt = grant;
                        burst_cnt_nxt  = '0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_box_draw_arbiter.sv
// Directed checks of sequence locking, round-robin/fixed arbitration, stalls and burst release.
module tb_box_draw_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  s_valid, s_ready, s_last;
    logic [26:0] s_box_x, s_box_y, s_box_w, s_box_h;
    logic [8:0]  s_box_color;
    logic        m_ready, m_valid, busy;
    logic [8:0]  out_box_x, out_box_y, out_box_w, out_box_h;
    logic [2:0]  out_box_color;
    logic [1:0]  m_src;
    int checks = 0;
    int errors = 0;

    box_draw_arbiter #(.MAX_BURST(8)) dut (
        .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_box_x(s_box_x), .s_box_y(s_box_y), .s_box_w(s_box_w),
        .s_box_h(s_box_h), .s_box_color(s_box_color), .m_ready(m_ready),
        .m_valid(m_valid), .out_box_x(out_box_x), .out_box_y(out_box_y),
        .out_box_w(out_box_w), .out_box_h(out_box_h), .out_box_color(out_box_color),
        .m_src(m_src), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset_n = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b0;
        s_box_x = '0; s_box_y = '0; s_box_w = '0; s_box_h = '0; s_box_color = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; s_valid = 3'b111; s_last = '0; m_ready = 1'b1;
        s_box_x = {9'd3, 9'd2, 9'd7}; s_box_y = '1; s_box_w = '1; s_box_h = '1; s_box_color = '1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL reset_m_src got %0d want 3", m_src); end
        checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL reset_s_ready got %b want 000", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if ({out_box_x, out_box_y, out_box_w, out_box_h, out_box_color} !== {9'd0, 9'd0, 9'd1, 9'd1, 3'd0})
            begin errors++; $display("FAIL reset_box got x%0d y%0d w%0d h%0d c%0d want 0 0 1 1 0",
                out_box_x, out_box_y, out_box_w, out_box_h, out_box_color); end
    endtask

`ifndef BOX_ARB_FIXED_PRIORITY_EN
    task automatic test_round_robin();
        int exp_src [7] = '{0, 3, 1, 3, 2, 3, 0};
        do_reset();
        s_valid = 3'b111; s_last = 3'b111; m_ready = 1'b1;
        s_box_x = {9'd30, 9'd20, 9'd10}; s_box_color = {3'd5, 3'd6, 3'd7};
        #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL rr_idle got %0d want 3", m_src); end
        for (int k = 0; k < 7; k++) begin
            @(negedge clock); #1;
            checks++; if (m_src !== 2'(exp_src[k])) begin errors++; $display("FAIL rr_src[%0d] got %0d want %0d", k, m_src, exp_src[k]); end
            if (exp_src[k] != 3) begin
                checks++; if (out_box_x !== 9'(10 * (exp_src[k] + 1))) begin errors++; $display("FAIL rr_x[%0d] got %0d want %0d", k, out_box_x, 10 * (exp_src[k] + 1)); end
                checks++; if (out_box_color !== 3'(7 - exp_src[k])) begin errors++; $display("FAIL rr_color[%0d] got %0d want %0d", k, out_box_color, 7 - exp_src[k]); end
                checks++; if (s_ready !== (3'b001 << exp_src[k])) begin errors++; $display("FAIL rr_ready[%0d] got %b", k, s_ready); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy[%0d] got %0b want 1", k, busy); end
            end
        end
    endtask
`endif

    task automatic test_lock();
        do_reset();
        s_valid = 3'b011; s_last = 3'b010; m_ready = 1'b1; s_box_x[8:0] = 9'd1;
        #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL lock_idle got %0d want 3", m_src); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            s_box_x[8:0] = 9'(k); s_last[0] = (k == 4);
            #1;
            checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL lock_src[%0d] got %0d want 0", k, m_src); end
            checks++; if (out_box_x !== 9'(k)) begin errors++; $display("FAIL lock_x[%0d] got %0d want %0d", k, out_box_x, k); end
            checks++; if (s_ready !== 3'b001) begin errors++; $display("FAIL lock_ready[%0d] got %b want 001", k, s_ready); end
        end
        @(negedge clock); s_valid[0] = 1'b0; #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL lock_gap got %0d want 3", m_src); end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd1 || s_ready !== 3'b010) begin errors++; $display("FAIL lock_next got src %0d ready %b want 1 010", m_src, s_ready); end
    endtask

    task automatic test_drop_valid();
        do_reset();
        s_valid = 3'b011; s_last = 3'b000; m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock); s_valid[0] = 1'b0; #1;
            checks++; if (m_valid !== 1'b0 || m_src !== 2'd0 || s_ready !== 3'b001)
                begin errors++; $display("FAIL drop_hold[%0d] got valid %0b src %0d ready %b want 0 0 001", k, m_valid, m_src, s_ready); end
        end
        @(negedge clock); s_valid[0] = 1'b1; s_last[0] = 1'b1; #1;
        checks++; if (m_valid !== 1'b1 || m_src !== 2'd0) begin errors++; $display("FAIL drop_resume got valid %0b src %0d want 1 0", m_valid, m_src); end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL drop_release got %0d want 3", m_src); end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd1) begin errors++; $display("FAIL drop_next got %0d want 1", m_src); end
    endtask

    task automatic test_stall();
        do_reset();
        s_valid = 3'b001; s_last = 3'b000; m_ready = 1'b0; s_box_x[8:0] = 9'd100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock); #1;
            checks++; if (m_valid !== 1'b1 || out_box_x !== 9'd100 || s_ready !== 3'b000 || m_src !== 2'd0)
                begin errors++; $display("FAIL stall[%0d] got valid %0b x %0d ready %b src %0d want 1 100 000 0", k, m_valid, out_box_x, s_ready, m_src); end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clock); m_ready = 1'b1; #1;
            checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL stall_burst[%0d] got %0d want 0", k, m_src); end
        end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL stall_release got %0d want 3", m_src); end
    endtask

    task automatic test_burst_cap();
        do_reset();
        s_valid = 3'b100; s_last = 3'b000; m_ready = 1'b1;
        #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL burst_idle got %0d want 3", m_src); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clock); s_valid = 3'b101; s_last[0] = 1'b1; #1;
            checks++; if (m_src !== 2'd2 || s_ready !== 3'b100) begin errors++; $display("FAIL burst_src[%0d] got src %0d ready %b want 2 100", k, m_src, s_ready); end
        end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL burst_release got %0d want 3", m_src); end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL burst_next got %0d want 0", m_src); end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd3) begin errors++; $display("FAIL burst_gap got %0d want 3", m_src); end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd2) begin errors++; $display("FAIL burst_regrant got %0d want 2", m_src); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        s_valid = 3'b010; s_last = 3'b000; m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            checks++; if (m_src !== 2'd1) begin errors++; $display("FAIL mid_src[%0d] got %0d want 1", k, m_src); end
        end
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1; s_valid = 3'b111; #1;
        checks++; if (m_valid !== 1'b0 || m_src !== 2'd3 || s_ready !== 3'b000)
            begin errors++; $display("FAIL mid_reset got valid %0b src %0d ready %b want 0 3 000", m_valid, m_src, s_ready); end
        @(negedge clock); #1;
        checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL mid_first got %0d want 0", m_src); end
    endtask

`ifdef BOX_ARB_FIXED_PRIORITY_EN
    task automatic test_fixed_priority();
        do_reset();
        s_valid = 3'b101; s_last = 3'b101; m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock); #1;
            checks++; if (m_src !== ((k % 2 == 0) ? 2'd0 : 2'd3)) begin errors++; $display("FAIL fixed_src[%0d] got %0d", k, m_src); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef BOX_ARB_FIXED_PRIORITY_EN
        test_fixed_priority();
`else
        test_round_robin();
`endif
        test_lock();
        test_drop_valid();
        test_stall();
        test_burst_cap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
